stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter N, default 4, number of input channels (N >= 2).
REQ-002 Parameter W, default 8, data width per channel.
REQ-003 Parameter MODE, default 0, selection mode: 0 = external select, 1 = round-robin.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-007 in_valid  input  N  per-channel beat valid.
REQ-008 in_last  input  N  per-channel end-of-packet marker, qualified by in_valid.
REQ-009 in_ready  output  N  per-channel beat accepted when in_valid[i] && in_ready[i].
REQ-010 sel  input  SW=$clog2(N)  requested channel; used only in MODE 0.
REQ-011 out_data  output  W  registered output beat.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_last  output  1  registered end-of-packet marker.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 grant  output  SW  channel currently locked.
REQ-016 busy  output  1  high while in LOCKED state.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and LOCKED; grant, busy and state SHALL be registered.
REQ-018 In IDLE, MODE 0 SHALL register grant <= sel and go to LOCKED when in_valid[sel] is high; otherwise the FSM SHALL stay in IDLE.
REQ-019 In IDLE, MODE 1 SHALL pick the first channel with in_valid high, searching from (ptr+1) mod N upward with wrap-around, register it as grant, and go to LOCKED; with no valid channel it SHALL stay in IDLE.
REQ-020 The round-robin pointer ptr SHALL load grant when a last beat transfers, so the finishing channel has lowest priority next.
REQ-021 All in_ready bits SHALL be low in IDLE; in LOCKED only in_ready[grant] SHALL be high, and only when !out_valid || out_ready.
REQ-022 A transfer SHALL register out_data, out_last from channel grant and set out_valid the next cycle: first beat visible 2 cycles after in_valid rises in IDLE, and 1 cycle per beat thereafter.
REQ-023 With out_valid && out_ready and no new transfer, out_valid SHALL clear; with both, out_valid SHALL stay high and the register SHALL reload (full throughput, no bubble).
REQ-024 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-025 Transfer of a beat with in_last high SHALL return the FSM to IDLE; re-arbitration takes one cycle.
REQ-026 In LOCKED, changes on sel and in_valid/in_last of other channels SHALL be ignored until the packet ends.
REQ-027 In MODE 0, an out-of-range sel (sel >= N, when N is not a power of two) SHALL be treated as no request.
REQ-028 A single-beat packet (in_last on the first beat) SHALL lock for exactly one transfer.

Reset
REQ-029 When rst_n is low: state = IDLE, grant = 0, ptr = N-1, out_valid = 0, out_last = 0, out_data = 0, busy = 0, in_ready = 0.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet and the output register contents with no further beats emitted; after release, arbitration restarts from IDLE.

Structure
REQ-031 The mode encodings (MODE_SEL = 0, MODE_RR = 1) and the state encoding SHALL be in a shared package stream_mux_pkg.
REQ-032 The round-robin search SHALL be a separate combinational sub-module rr_pick (N-bit request, ptr in, index and found out); the FSM and output register stay in stream_mux_n.

Verification
REQ-033 MODE 0, N=4, W=8, sel=2: ch2 sends 3-beat packet A0, A1, A2 (last on A2), out_ready=1 -> out shows A0..A2 on consecutive cycles, first 2 cycles after in_valid, out_last with A2 only.
REQ-034 MODE 0: switch sel 2->1 during a packet -> remaining ch2 beats still delivered; ch1 granted only after last beat.
REQ-035 MODE 1: all 4 channels continuously valid with single-beat packets -> grant order 0,1,2,3,0, one packet per 2 cycles.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles mid-packet -> out_data stable, in_ready[grant]=0; no beat lost or duplicated on release.
REQ-037 Reset asserted during beat 2 of a 4-beat packet -> out_valid=0 and busy=0 immediately; new packet after release is delivered intact.
REQ-038 MODE 1, N=3 (non-power-of-two), only ch2 then ch0 valid -> wrap-around grants 2 then 0; MODE 0 with sel=3 -> no grant.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared definitions for the N-channel packet stream multiplexer:
//   selection-mode encodings and the arbiter FSM state encoding.
package stream_mux_pkg;

    localparam int unsigned MODE_SEL = 0;  // channel chosen by external sel input
    localparam int unsigned MODE_RR  = 1;  // round-robin over valid channels

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin search. Returns the first requesting channel
//   found when scanning upward from (i_ptr + 1) mod N, wrapping around, so
//   channel i_ptr itself has the lowest priority.
//   Ports:
//     i_req   [N]  per-channel request
//     i_ptr   [SW] last-served channel
//     o_idx   [SW] chosen channel (0 when nothing requests)
//     o_found      at least one channel requests
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [SW-1:0] o_idx,
    output logic          o_found
);

    logic [SW-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        // Scan farthest-first so the nearest requester after i_ptr is kept last.
        for (int k = int'(N); k > 0; k--) begin
            w_cand = SW'((32'(i_ptr) + 32'(k)) % N);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n
//   Packet-level N:1 stream multiplexer. Once a channel is granted it stays
//   locked until its last beat transfers, then the arbiter returns to idle
//   and re-arbitrates. The output beat is held in a single register that
//   supports full throughput and stalls cleanly under backpressure.
//   Parameters: N channels, W data bits, MODE (MODE_SEL external / MODE_RR).
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     in_data/in_valid/in_last     per-channel input beats (channel i at [i*W +: W])
//     in_ready                     per-channel accept, only the locked channel
//     sel                          requested channel (MODE_SEL only)
//     out_data/out_valid/out_last  registered output beat
//     out_ready                    downstream accept
//     grant                        locked channel
//     busy                         high while locked
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = MODE_SEL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(N);

    state_e        r_state;
    logic [SW-1:0] r_grant;
    logic [SW-1:0] r_ptr;
    logic          r_busy;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic [W-1:0]  w_ch_data [N];
    logic [SW-1:0] w_rr_idx;
    logic          w_rr_found;
    logic [SW-1:0] w_req_idx;
    logic          w_req_found;
    logic          w_out_free;
    logic          w_xfer;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_ch_data[i] = in_data[i*W +: W];
        end
    end

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

    // Request seen while idle; an out-of-range sel counts as no request.
    always_comb begin
        if (MODE == MODE_RR) begin
            w_req_idx   = w_rr_idx;
            w_req_found = w_rr_found;
        end else begin
            w_req_idx   = sel;
            w_req_found = (32'(sel) < N) && in_valid[sel];
        end
    end

    // Output register can take a beat when empty or being drained this cycle.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_xfer     = (r_state == StLocked) && in_valid[r_grant] && w_out_free;

    always_comb begin
        in_ready = '0;
        if ((r_state == StLocked) && w_out_free) begin
            in_ready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_grant     <= '0;
            r_ptr       <= SW'(N - 1);
            r_busy      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_ch_data[r_grant];
                r_out_last  <= in_last[r_grant];
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_req_found) begin
                        r_grant <= w_req_idx;
                        r_state <= StLocked;
                        r_busy  <= 1'b1;
                    end
                end
                StLocked: begin
                    if (w_xfer && in_last[r_grant]) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_grant;  // finishing channel gets lowest priority
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n
//   Directed self-checking bench for stream_mux_n. Four instances share two
//   stimulus buses: N=4 in select mode (a) and round-robin mode (b), N=3 in
//   round-robin mode (c) and select mode (e). Every test starts from reset.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // N=4 bus
    logic [31:0] d4;
    logic [3:0]  v4, l4;
    logic [1:0]  sel4;
    logic        o4;
    logic [3:0]  a_rdy, b_rdy;
    logic [7:0]  a_data, b_data;
    logic        a_valid, a_last, a_busy, b_valid, b_last, b_busy;
    logic [1:0]  a_grant, b_grant;

    // N=3 bus
    logic [23:0] d3;
    logic [2:0]  v3, l3;
    logic [1:0]  sel3;
    logic        o3;
    logic [2:0]  c_rdy, e_rdy;
    logic [7:0]  c_data, e_data;
    logic        c_valid, c_last, c_busy, e_valid, e_last, e_busy;
    logic [1:0]  c_grant, e_grant;

    stream_mux_n #(.N(4), .W(8), .MODE(MODE_SEL)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_last(l4),
        .in_ready(a_rdy), .sel(sel4), .out_data(a_data), .out_valid(a_valid),
        .out_last(a_last), .out_ready(o4), .grant(a_grant), .busy(a_busy)
    );

    stream_mux_n #(.N(4), .W(8), .MODE(MODE_RR)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_last(l4),
        .in_ready(b_rdy), .sel(sel4), .out_data(b_data), .out_valid(b_valid),
        .out_last(b_last), .out_ready(o4), .grant(b_grant), .busy(b_busy)
    );

    stream_mux_n #(.N(3), .W(8), .MODE(MODE_RR)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_last(l3),
        .in_ready(c_rdy), .sel(sel3), .out_data(c_data), .out_valid(c_valid),
        .out_last(c_last), .out_ready(o3), .grant(c_grant), .busy(c_busy)
    );

    stream_mux_n #(.N(3), .W(8), .MODE(MODE_SEL)) u_e (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_last(l3),
        .in_ready(e_rdy), .sel(sel3), .out_data(e_data), .out_valid(e_valid),
        .out_last(e_last), .out_ready(o3), .grant(e_grant), .busy(e_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d4 = '0; v4 = '0; l4 = '0; sel4 = '0; o4 = 1'b1;
        d3 = '0; v3 = '0; l3 = '0; sel3 = 2'd3; o3 = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        v4 = 4'hF; l4 = 4'hF; sel4 = 2'd1;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", a_valid); end
        total++; if (a_last !== 1'b0) begin bad++; $display("FAIL reset_a_last got=%b want=0", a_last); end
        total++; if (a_data !== 8'h00) begin bad++; $display("FAIL reset_a_data got=%h want=00", a_data); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy got=%b want=0", a_busy); end
        total++; if (a_grant !== 2'd0) begin bad++; $display("FAIL reset_a_grant got=%0d want=0", a_grant); end
        total++; if (a_rdy !== 4'b0000) begin bad++; $display("FAIL reset_a_rdy got=%b want=0000", a_rdy); end
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL reset_b_busy got=%b want=0", b_busy); end
        total++; if (b_rdy !== 4'b0000) begin bad++; $display("FAIL reset_b_rdy got=%b want=0000", b_rdy); end
        v4 = 4'h0; l4 = 4'h0;
        rst_n = 1'b1;
        tick();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy got=%b want=0", a_busy); end
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_b_busy got=%b want=0", b_busy); end
    endtask

    // ch2 sends A0, A1, A2 with sel=2.
    task automatic test_basic();
        do_reset();
        sel4 = 2'd2; v4 = 4'b0100; d4[23:16] = 8'hA0;
        tick();
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL basic_lock_busy got=%b want=1", a_busy); end
        total++; if (a_grant !== 2'd2) begin bad++; $display("FAIL basic_lock_grant got=%0d want=2", a_grant); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL basic_lock_valid got=%b want=0", a_valid); end
        total++; if (a_rdy !== 4'b0100) begin bad++; $display("FAIL basic_rdy got=%b want=0100", a_rdy); end
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hA0 || a_last !== 1'b0) begin
            bad++; $display("FAIL basic_beat0 got=%b/%h/%b want=1/a0/0", a_valid, a_data, a_last); end
        d4[23:16] = 8'hA1;
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hA1 || a_last !== 1'b0) begin
            bad++; $display("FAIL basic_beat1 got=%b/%h/%b want=1/a1/0", a_valid, a_data, a_last); end
        d4[23:16] = 8'hA2; l4 = 4'b0100;
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hA2 || a_last !== 1'b1) begin
            bad++; $display("FAIL basic_beat2 got=%b/%h/%b want=1/a2/1", a_valid, a_data, a_last); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL basic_end_busy got=%b want=0", a_busy); end
        v4 = 4'b0; l4 = 4'b0;
        tick();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", a_valid); end
    endtask

    // sel moves 2->1 while ch2 is locked; ch1 waits for ch2's last beat.
    task automatic test_sel_switch();
        do_reset();
        sel4 = 2'd2; v4 = 4'b0110; l4 = 4'b0010;
        d4[15:8] = 8'hC0; d4[23:16] = 8'hB0;
        tick();
        total++; if (a_grant !== 2'd2) begin bad++; $display("FAIL sw_lock_grant got=%0d want=2", a_grant); end
        sel4 = 2'd1;
        tick();
        total++; if (a_data !== 8'hB0 || a_grant !== 2'd2 || a_busy !== 1'b1) begin
            bad++; $display("FAIL sw_beat0 got=%h/%0d/%b want=b0/2/1", a_data, a_grant, a_busy); end
        d4[23:16] = 8'hB1;
        tick();
        total++; if (a_data !== 8'hB1 || a_grant !== 2'd2) begin
            bad++; $display("FAIL sw_beat1 got=%h/%0d want=b1/2", a_data, a_grant); end
        d4[23:16] = 8'hB2; l4 = 4'b0110;
        tick();
        total++; if (a_data !== 8'hB2 || a_last !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL sw_beat2 got=%h/%b/%b want=b2/1/0", a_data, a_last, a_busy); end
        v4 = 4'b0010; l4 = 4'b0010;
        tick();
        total++; if (a_grant !== 2'd1 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
            bad++; $display("FAIL sw_relock got=%0d/%b/%b want=1/1/0", a_grant, a_busy, a_valid); end
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hC0 || a_last !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL sw_ch1 got=%b/%h/%b/%b want=1/c0/1/0", a_valid, a_data, a_last, a_busy); end
        v4 = 4'b0; l4 = 4'b0;
    endtask

    // All four channels valid with single-beat packets in round-robin mode.
    task automatic test_rr();
        logic [1:0] exp_g [5];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        v4 = 4'hF; l4 = 4'hF; d4 = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (b_grant !== exp_g[k] || b_busy !== 1'b1 || b_valid !== 1'b0) begin
                bad++; $display("FAIL rr_lock%0d got=%0d/%b/%b want=%0d/1/0", k, b_grant, b_busy, b_valid, exp_g[k]); end
            tick();
            total++; if (b_valid !== 1'b1 || b_data !== (8'h10 + {6'd0, exp_g[k]}) || b_last !== 1'b1 || b_busy !== 1'b0) begin
                bad++; $display("FAIL rr_beat%0d got=%b/%h/%b/%b want=1/%h/1/0", k, b_valid, b_data, b_last, b_busy, 8'h10 + {6'd0, exp_g[k]}); end
        end
        v4 = 4'h0; l4 = 4'h0;
    endtask

    // 4-beat packet on ch0 with out_ready low for 5 cycles after the first beat.
    task automatic test_backpressure();
        logic [7:0] beats [4];
        int si;
        int so;
        logic hs_in;
        logic hs_out;
        beats = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        si = 0;
        so = 0;
        do_reset();
        sel4 = 2'd0;
        for (int c = 0; c < 16; c++) begin
            o4       = !(c >= 2 && c <= 6);
            v4[0]    = (si < 4);
            d4[7:0]  = beats[(si < 4) ? si : 3];
            l4[0]    = (si == 3);
            #1;
            if (c >= 2 && c <= 6) begin
                total++; if (a_valid !== 1'b1 || a_data !== 8'hD0 || a_rdy[0] !== 1'b0) begin
                    bad++; $display("FAIL bp_stall%0d got=%b/%h/%b want=1/d0/0", c, a_valid, a_data, a_rdy[0]); end
            end
            hs_in  = v4[0] && a_rdy[0];
            hs_out = a_valid && o4;
            if (hs_out) begin
                total++;
                if (so >= 4) begin
                    bad++; $display("FAIL bp_extra_beat got=%h want=none", a_data);
                end else if (a_data !== beats[so] || a_last !== (so == 3)) begin
                    bad++; $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", so, a_data, a_last, beats[so], so == 3);
                end
                so++;
            end
            tick();
            if (hs_in) si++;
        end
        total++; if (so !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", so); end
        total++; if (a_busy !== 1'b0 || a_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end got=%b/%b want=0/0", a_busy, a_valid); end
        idle_inputs();
    endtask

    // Reset during beat 2 of a 4-beat ch3 packet, then a fresh 2-beat packet.
    task automatic test_reset_mid();
        do_reset();
        sel4 = 2'd3; v4 = 4'b1000; d4[31:24] = 8'hE0;
        tick();
        tick();
        d4[31:24] = 8'hE1;
        tick();
        total++; if (a_data !== 8'hE1) begin bad++; $display("FAIL rm_pre got=%h want=e1", a_data); end
        d4[31:24] = 8'hE2;
        rst_n = 1'b0;
        #1;
        total++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_data !== 8'h00 || a_rdy !== 4'b0) begin
            bad++; $display("FAIL rm_async got=%b/%b/%h/%b want=0/0/00/0000", a_valid, a_busy, a_data, a_rdy); end
        d4[31:24] = 8'hF0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (a_valid !== 1'b0 || a_busy !== 1'b1 || a_grant !== 2'd3) begin
            bad++; $display("FAIL rm_relock got=%b/%b/%0d want=0/1/3", a_valid, a_busy, a_grant); end
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hF0 || a_last !== 1'b0) begin
            bad++; $display("FAIL rm_new0 got=%b/%h/%b want=1/f0/0", a_valid, a_data, a_last); end
        d4[31:24] = 8'hF1; l4 = 4'b1000;
        tick();
        total++; if (a_valid !== 1'b1 || a_data !== 8'hF1 || a_last !== 1'b1 || a_busy !== 1'b0) begin
            bad++; $display("FAIL rm_new1 got=%b/%h/%b/%b want=1/f1/1/0", a_valid, a_data, a_last, a_busy); end
        idle_inputs();
    endtask

    // N=3: round-robin wrap 2 then 0; select mode with sel=3 never grants.
    task automatic test_n3();
        do_reset();
        v3 = 3'b100; l3 = 3'b100; d3[23:16] = 8'h22;
        tick();
        total++; if (c_grant !== 2'd2 || c_busy !== 1'b1) begin
            bad++; $display("FAIL n3_g2 got=%0d/%b want=2/1", c_grant, c_busy); end
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL n3_sel3_a got=%b want=0", e_busy); end
        tick();
        total++; if (c_valid !== 1'b1 || c_data !== 8'h22 || c_last !== 1'b1) begin
            bad++; $display("FAIL n3_beat2 got=%b/%h/%b want=1/22/1", c_valid, c_data, c_last); end
        v3 = 3'b001; l3 = 3'b001; d3[7:0] = 8'h30;
        tick();
        total++; if (c_grant !== 2'd0 || c_busy !== 1'b1) begin
            bad++; $display("FAIL n3_g0 got=%0d/%b want=0/1", c_grant, c_busy); end
        tick();
        total++; if (c_valid !== 1'b1 || c_data !== 8'h30) begin
            bad++; $display("FAIL n3_beat0 got=%b/%h want=1/30", c_valid, c_data); end
        v3 = 3'b111; l3 = 3'b111;
        tick();
        tick();
        total++; if (e_busy !== 1'b0 || e_valid !== 1'b0 || e_rdy !== 3'b000 || e_grant !== 2'd0) begin
            bad++; $display("FAIL n3_sel3_b got=%b/%b/%b/%0d want=0/0/000/0", e_busy, e_valid, e_rdy, e_grant); end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_sel_switch();
        test_rr();
        test_backpressure();
        test_reset_mid();
        test_n3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
